// File: rtl/shift_add_mult16.sv
// Sequential 16x16 shift-and-add multiplier; the per-iteration add uses a 16-bit carry-lookahead adder.
// Latency WIDTH cycles from accept to out_valid (WIDTH+1 with SHIFT_ADD_MULT16_SIGNED_EN); in_ready only in IDLE.
// Backpressure: DONE holds prod until out_ready; SHIFT_ADD_MULT16_SIGNED_EN selects two's-complement operands.

module cla_add16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  always_comb begin
    g = x & y;
    p = x ^ y;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    // Group carries are fully expanded so no carry depends on another group's carry.
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    sum  = p ^ c;
    cout = gc[4];
  end
endmodule

module shift_add_mult16 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] p_reg;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   ld_a, ld_b, add_sum;
  logic               add_cout;
  logic [WIDTH:0]     upper;
`ifdef SHIFT_ADD_MULT16_SIGNED_EN
  logic               neg;
`endif

  cla_add16 u_add (
    .x    (p_reg[2*WIDTH-1:WIDTH]),
    .y    (mcand),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
`ifdef SHIFT_ADD_MULT16_SIGNED_EN
    // Magnitudes; the most negative value maps onto its unsigned pattern.
    ld_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    ld_b = b[WIDTH-1] ? (~b + 1'b1) : b;
`else
    ld_a = a;
    ld_b = b;
`endif
    upper = p_reg[0] ? {add_cout, add_sum} : {1'b0, p_reg[2*WIDTH-1:WIDTH]};
  end

  always_comb begin
    state_n   = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == RUN) || (state == FIX);
    case (state)
      IDLE: if (in_valid) state_n = RUN;
      RUN: begin
        if (cnt == LAST) begin
`ifdef SHIFT_ADD_MULT16_SIGNED_EN
          state_n = FIX;
`else
          state_n = DONE;
`endif
        end
      end
      FIX:     state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      p_reg <= '0;
      cnt   <= '0;
`ifdef SHIFT_ADD_MULT16_SIGNED_EN
      neg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= ld_a;
            p_reg <= {{WIDTH{1'b0}}, ld_b};
            cnt   <= '0;
`ifdef SHIFT_ADD_MULT16_SIGNED_EN
            neg   <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          p_reg <= {upper, p_reg[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
        end
`ifdef SHIFT_ADD_MULT16_SIGNED_EN
        FIX: if (neg) p_reg <= ~p_reg + 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign prod = p_reg;
endmodule

// File: tb/tb_shift_add_mult16.sv
// Randomized and directed bench for shift_add_mult16 against an arithmetic product model.
module tb_shift_add_mult16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] prod;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef SHIFT_ADD_MULT16_SIGNED_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 16;
`endif

  shift_add_mult16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
`ifdef SHIFT_ADD_MULT16_SIGNED_EN
    logic signed [31:0] r;
    r = $signed(x) * $signed(y);
    return r;
`else
    return {16'b0, x} * {16'b0, y};
`endif
  endfunction

  // One full transaction; hold = cycles of out_ready low once the result is up.
  task automatic do_op(input logic [15:0] oa, input logic [15:0] ob, input int hold, input bit pulse);
    logic [31:0] exp;
    int cyc;
    exp = model(oa, ob);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    out_ready = (hold == 0);
    a = oa;
    b = ob;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    chk("busy_after_accept", busy, 1);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      if (!out_valid) cyc++;
    end
    chk("latency", cyc, LAT);
    chk("prod", prod, exp);
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 3) begin
        in_valid = 1'b1;
        a = 16'hFFFF;
        b = 16'hFFFF;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("hold_prod", prod, exp);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_return", in_ready, 1);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_prod", prod, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(16'd3, 16'd5, 0, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 0, 1'b0);
    do_op(16'h1234, 16'h0000, 0, 1'b0);
    do_op(16'h0000, 16'hFFFF, 0, 1'b0);
    do_op(16'd7, 16'd9, 10, 1'b1);

    // Abort mid-computation with an asynchronous reset.
    @(negedge clk);
    a = 16'd11;
    b = 16'd13;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_prod", prod, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'd2, 16'd2, 0, 1'b0);

`ifdef SHIFT_ADD_MULT16_SIGNED_EN
    do_op(16'hFFFD, 16'd5, 0, 1'b0);
    do_op(16'h8000, 16'h8000, 0, 1'b0);
    do_op(16'hFFFF, 16'd1, 1, 1'b0);
`endif

    for (int t = 0; t < 20; t++)
      do_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
